// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared states, hold code and per-bit JK excitation function for jk_excite_driver
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // {J,K} that leaves a JK flop unchanged
    localparam logic [1:0] JK_HOLD = 2'b00;

    // Returns {J,K} moving one flop from cur to nxt; dc fills the don't-care input
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt, input logic dc);
        logic [1:0] jk;
        if (cur) begin
            jk = {dc, ~nxt};
        end else begin
            jk = {nxt, dc};
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite_cell.sv
// rtl/jk_excite_cell.sv - combinational single-bit JK excitation (current -> next Q)
module jk_excite_cell
    import jk_pkg::*;
#(
    parameter logic DC_FILL = 1'b0
) (
    input  logic cur,
    input  logic nxt,
    output logic j,
    output logic k
);

    assign {j, k} = jk_excite(cur, nxt, DC_FILL);

endmodule

// File: rtl/jk_excite_driver.sv
// rtl/jk_excite_driver.sv - drives J/K of an external JK bank to reach a target word; JK_VERIFY_EN adds read-back check with retry
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DC_FILL   = 0,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] tgt_d;
    logic [WIDTH-1:0] exc_nxt;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             done_d;

`ifdef JK_VERIFY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_d;
    logic          err_q;
    logic          err_d;
    assign err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^MAX_RETRY;
    assign err        = 1'b0;
`endif

    // At acceptance the excitation targets the incoming word; on a retry it targets the latched one
    assign exc_nxt = (state == IDLE) ? tgt_data : tgt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_excite_cell #(
            .DC_FILL(DC_FILL != 0)
        ) u_cell (
            .cur(q_fb[i]),
            .nxt(exc_nxt[i]),
            .j  (exc_j[i]),
            .k  (exc_k[i])
        );
    end

    assign tgt_ready = (state == IDLE) && !rst;
    assign busy      = (state == DRIVE) || (state == CHECK);

    always_comb begin
        state_d = state;
        tgt_d   = tgt_q;
        j_d     = {WIDTH{JK_HOLD[1]}};
        k_d     = {WIDTH{JK_HOLD[0]}};
        done_d  = 1'b0;
`ifdef JK_VERIFY_EN
        retry_d = retry_cnt;
        err_d   = err_q;
`endif
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    state_d = DRIVE;
                    tgt_d   = tgt_data;
                    j_d     = exc_j;
                    k_d     = exc_k;
`ifdef JK_VERIFY_EN
                    retry_d = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            DRIVE: begin
`ifdef JK_VERIFY_EN
                state_d = CHECK;
`else
                state_d = IDLE;
                done_d  = 1'b1;
`endif
            end
            CHECK: begin
`ifdef JK_VERIFY_EN
                if (q_fb == tgt_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (int'(retry_cnt) < MAX_RETRY) begin
                    state_d = DRIVE;
                    retry_d = retry_cnt + 1'b1;
                    j_d     = exc_j;
                    k_d     = exc_k;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tgt_q     <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
`ifdef JK_VERIFY_EN
            retry_cnt <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            tgt_q     <= tgt_d;
            j         <= j_d;
            k         <= k_d;
            done      <= done_d;
`ifdef JK_VERIFY_EN
            retry_cnt <= retry_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule
